// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the 5-stage MIPS pipeline.
// Registers the memory-stage result, extracts big-endian load data, drives
// the register-file write port and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic              in_jal,
  input  logic [4:0]        in_wr_addr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [DATA_W-1:0] in_link_addr,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              jump_and_link,
  output logic [DATA_W-1:0] link_addr,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              jal_q, jal_d;
  load_type_e        load_type_q, load_type_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] link_addr_q, link_addr_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;

  logic [1:0]        byte_off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;

  // Next-state: flush beats stall; reserved load codes are folded to LW at capture.
  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    jal_d          = jal_q;
    load_type_d    = load_type_q;
    wr_addr_d      = wr_addr_q;
    alu_result_d   = alu_result_q;
    mem_rdata_d    = mem_rdata_q;
    link_addr_d    = link_addr_q;
    retire_count_d = retire_count_q;

    if (valid_q && !stall) begin
      retire_count_d = retire_count_q + CNT_W'(1);
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      reg_write_d  = in_reg_write;
      mem_to_reg_d = in_mem_to_reg;
      jal_d        = in_jal;
      wr_addr_d    = in_wr_addr;
      alu_result_d = in_alu_result;
      mem_rdata_d  = in_mem_rdata;
      link_addr_d  = in_link_addr;
      case (in_load_type)
        3'd1:    load_type_d = LD_B;
        3'd2:    load_type_d = LD_BU;
        3'd3:    load_type_d = LD_H;
        3'd4:    load_type_d = LD_HU;
        default: load_type_d = LD_W;
      endcase
    end
  end

  // Stage registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      jal_q          <= 1'b0;
      load_type_q    <= LD_W;
      wr_addr_q      <= '0;
      alu_result_q   <= '0;
      mem_rdata_q    <= '0;
      link_addr_q    <= '0;
      retire_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      jal_q          <= jal_d;
      load_type_q    <= load_type_d;
      wr_addr_q      <= wr_addr_d;
      alu_result_q   <= alu_result_d;
      mem_rdata_q    <= mem_rdata_d;
      link_addr_q    <= link_addr_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Big-endian lane selection and sign/zero extension of load data.
  always_comb begin
    byte_off = alu_result_q[1:0];
    case (byte_off)
      2'd0:    byte_sel = mem_rdata_q[31:24];
      2'd1:    byte_sel = mem_rdata_q[23:16];
      2'd2:    byte_sel = mem_rdata_q[15:8];
      default: byte_sel = mem_rdata_q[7:0];
    endcase
    half_sel = byte_off[1] ? mem_rdata_q[15:0] : mem_rdata_q[31:16];
    case (load_type_q)
      LD_B:    load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = mem_rdata_q;
    endcase
  end

  // Writeback port, driven only from the stage registers.
  always_comb begin
    wb_valid      = valid_q;
    retire_count  = retire_count_q;
    jump_and_link = valid_q & jal_q;
    wr_en         = valid_q & (reg_write_q | jal_q);
    wr_addr       = jal_q ? 5'd31 : wr_addr_q;
    link_addr     = jump_and_link ? link_addr_q : '0;
    if (!valid_q) begin
      wr_data = '0;
    end else if (jal_q) begin
      wr_data = link_addr_q;
    end else if (!mem_to_reg_q) begin
      wr_data = alu_result_q;
    end else begin
      wr_data = load_data;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_wb_stage;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic [2:0]  in_load_type = 3'd0;
  logic        in_jal = 1'b0;
  logic [4:0]  in_wr_addr = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic [31:0] in_mem_rdata = 32'd0;
  logic [31:0] in_link_addr = 32'd0;

  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             jump_and_link;
  logic [31:0]      link_addr;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_count;

  mem_wb_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_load_type(in_load_type), .in_jal(in_jal), .in_wr_addr(in_wr_addr),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_link_addr(in_link_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .jump_and_link(jump_and_link),
    .link_addr(link_addr), .wb_valid(wb_valid), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the stage contents.
  bit          m_valid = 0;
  bit          m_rw = 0, m_m2r = 0, m_jal = 0;
  int unsigned m_lt = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_alu = 32'd0, m_rdata = 32'd0, m_link = 32'd0;
  int unsigned m_count = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0;
      m_count = 0;
    end else begin
      if (m_valid && !stall) m_count = (m_count + 1) % (1 << CNT_W);
      if (flush) begin
        m_valid = 0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_rw    = in_reg_write;
        m_m2r   = in_mem_to_reg;
        m_jal   = in_jal;
        m_lt    = in_load_type;
        m_addr  = in_wr_addr;
        m_alu   = in_alu_result;
        m_rdata = in_mem_rdata;
        m_link  = in_link_addr;
      end
    end
  end

  function automatic logic [31:0] load_value(input int unsigned lt, input logic [31:0] rdata,
                                             input int unsigned off);
    int unsigned b, h;
    b = (rdata >> (8 * (3 - off))) & 32'hFF;
    h = (off >= 2) ? (rdata & 32'hFFFF) : (rdata >> 16);
    case (lt)
      1:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2:       return b;
      3:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4:       return h;
      default: return rdata;
    endcase
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] e_data;
    bit          e_jal;
    e_jal = m_valid && m_jal;
    if (!m_valid)    e_data = 32'd0;
    else if (m_jal)  e_data = m_link;
    else if (!m_m2r) e_data = m_alu;
    else             e_data = load_value(m_lt, m_rdata, m_alu % 4);
    check("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
    check("wr_en", {31'd0, wr_en}, {31'd0, m_valid && (m_rw || m_jal)});
    check("jump_and_link", {31'd0, jump_and_link}, {31'd0, e_jal});
    check("wr_data", wr_data, e_data);
    check("link_addr", link_addr, e_jal ? m_link : 32'd0);
    check("retire_count", {28'd0, retire_count}, m_count);
    if (m_valid) check("wr_addr", {27'd0, wr_addr}, m_jal ? 32'd31 : {27'd0, m_addr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input bit jal,
                       input logic [2:0] lt, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] link);
    in_valid      = v;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_jal        = jal;
    in_load_type  = lt;
    in_wr_addr    = a;
    in_alu_result = alu;
    in_mem_rdata  = rd;
    in_link_addr  = link;
  endtask

  logic [2:0]  ld_type [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd0};
  int unsigned ld_off  [7] = '{0, 0, 2, 2, 0, 0, 3};
  logic [31:0] ld_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'h0000_7F01,
                               32'h0000_80FF, 32'hFFFF_80FF, 32'h80FF_7F01};

  initial begin
    int unsigned cnt_hold;

    // Reset holds everything at zero even with a valid instruction presented.
    rst = 1'b1;
    drive(1, 1, 0, 0, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 32'd0);
    tick();
    tick();
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_retire_count", {28'd0, retire_count}, 32'd0);
    check("rst_jal", {31'd0, jump_and_link}, 32'd0);
    check("rst_link_addr", link_addr, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);

    // First ALU op after reset.
    rst = 1'b0;
    tick();
    check("alu_wr_en", {31'd0, wr_en}, 32'd1);
    check("alu_wr_addr", {27'd0, wr_addr}, 32'd5);
    check("alu_wr_data", wr_data, 32'h0000_1234);
    check("alu_count_before", {28'd0, retire_count}, 32'd0);
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("alu_count_after", {28'd0, retire_count}, 32'd1);

    // Load extraction table.
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 1, 0, ld_type[i], 5'd8, 32'h0000_0100 | ld_off[i], 32'h80FF_7F01, 32'd0);
      tick();
      check($sformatf("load_%0d", i), wr_data, ld_exp[i]);
    end

    // JAL to r0 is redirected to r31.
    drive(1, 0, 0, 1, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'h0040_0018);
    tick();
    check("jal_flag", {31'd0, jump_and_link}, 32'd1);
    check("jal_wr_en", {31'd0, wr_en}, 32'd1);
    check("jal_wr_addr", {27'd0, wr_addr}, 32'd31);
    check("jal_wr_data", wr_data, 32'h0040_0018);
    check("jal_link_addr", link_addr, 32'h0040_0018);

    // Stall holds a valid instruction for three cycles.
    drive(1, 1, 0, 0, 3'd0, 5'd7, 32'hCAFE_0001, 32'd0, 32'd0);
    tick();
    check("stall_pre_data", wr_data, 32'hCAFE_0001);
    cnt_hold = m_count;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, $urandom_range(0, 1), 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      tick();
      check("stall_wr_data", wr_data, 32'hCAFE_0001);
      check("stall_wr_en", {31'd0, wr_en}, 32'd1);
      check("stall_wr_addr", {27'd0, wr_addr}, 32'd7);
      check("stall_count", {28'd0, retire_count}, cnt_hold);
    end

    // Flush wins over stall.
    flush = 1'b1;
    tick();
    check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_wr_en", {31'd0, wr_en}, 32'd0);
    check("flush_wr_data", wr_data, 32'd0);
    check("flush_count", {28'd0, retire_count}, cnt_hold);
    flush = 1'b0;
    stall = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // Counter wrap: 15 retirements reach all-ones, the 16th wraps to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 3'd0, 5'(i + 1), 32'(i), 32'd0, 32'd0);
      tick();
    end
    check("wrap_count_15", {28'd0, retire_count}, 32'd15);
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("wrap_count_0", {28'd0, retire_count}, 32'd0);

    // Asynchronous reset between edges drops the held instruction at once.
    drive(1, 1, 0, 0, 3'd0, 5'd9, 32'h0000_0099, 32'd0, 32'd0);
    tick();
    check("midrst_pre_valid", {31'd0, wb_valid}, 32'd1);
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    tick();
    rst = 1'b0;

    // Randomized traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, 3'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom);
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
